// File: rtl/iob_rom_streamer_pkg.sv
// Shared types and constants for the ROM read streamer.
package iob_rom_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int SFIFO_DEPTH = 2;

endpackage

// File: rtl/iob_rom_stream_fifo.sv
// Two-entry synchronous FIFO buffering ROM words ahead of the stream port.
module iob_rom_stream_fifo
    import iob_rom_streamer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic [DATA_W-1:0]                    wdata_i,
    input  logic                                 pop_i,
    output logic [DATA_W-1:0]                    rdata_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [$clog2(SFIFO_DEPTH+1)-1:0]     count_o
);

    localparam int CNT_W = $clog2(SFIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(SFIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [SFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SFIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(SFIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/iob_rom_streamer.sv
// Walks a ROM address range and streams the words out on valid/ready with last.
module iob_rom_streamer
    import iob_rom_streamer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int CNT_W = $clog2(SFIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(SFIFO_DEPTH);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  issued_d;
    logic [LEN_W-1:0]  out_cnt_q;
    logic [LEN_W-1:0]  out_cnt_d;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              rd_issue;
    logic              last_issue;
    logic [CNT_W:0]    pending;

    assign pop = m_valid & m_ready;

    // Words already buffered or on their way, after this cycle's pop.
    assign pending = {1'b0, fifo_cnt}
                   + {{CNT_W{1'b0}}, inflight_q}
                   - {{CNT_W{1'b0}}, pop};

    assign rd_issue = (state_q == ST_RUN)
                   && (issued_q != len_q)
                   && (pending < CREDITS)
                   && !(fifo_full && !pop);

    always_comb begin
        addr_d    = addr_q;
        issued_d  = issued_q;
        out_cnt_d = out_cnt_q;
        if (rd_issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + LEN_W'(1);
        end
        if (pop) begin
            out_cnt_d = out_cnt_q + LEN_W'(1);
        end
    end

    assign last_issue = rd_issue && (issued_d == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= rd_issue;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_q    <= base_addr;
                            len_q     <= len;
                            issued_q  <= '0;
                            out_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_issue) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    iob_rom_stream_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .wdata_i (rom_r_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_r_en = rd_issue;
    assign rom_addr = addr_q;
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_head;
    assign m_last   = m_valid && ((out_cnt_q + LEN_W'(1)) == len_q);

endmodule

// File: tb/tb_iob_rom_streamer.sv
// Scoreboard bench for iob_rom_streamer against a registered-read ROM model.
module tb_iob_rom_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       rom_r_en;
    logic [3:0] rom_addr;
    logic [7:0] rom_r_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] addr_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued_n = 0;
    int acc_n = 0;
    int done_n = 0;
    int valid_n = 0;
    int max_pend = 0;
    int pend;
    int start_cyc, first_v_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
    logic armed = 1'b0;
    logic hs_armed = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;
    exp_t e;

    iob_rom_streamer #(
        .DATA_W (8),
        .ADDR_W (4),
        .LEN_W  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_r_en   (rom_r_en),
        .rom_addr   (rom_addr),
        .rom_r_data (rom_r_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: rom[i] = i + 32, one-cycle registered read
    logic [7:0] rom_q = 8'h00;
    always @(posedge clk) begin
        if (rom_r_en) rom_q <= 8'({4'd0, rom_addr}) + 8'd32;
    end
    assign rom_r_data = rom_q;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            pend = issued_n - acc_n;
            if (pend > max_pend) max_pend = pend;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (rom_r_en === 1'b1) begin
                issued_n++;
                addr_log.push_back(rom_addr);
            end
            if (m_valid === 1'b1) begin
                valid_n++;
                if (armed) begin
                    first_v_cyc = cyc;
                    armed = 1'b0;
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h last=%b, required none",
                             m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        errors++;
                        $display("FAIL word: got data=%h last=%b, required data=%h last=%b",
                                 m_data, m_last, e.d, e.l);
                    end
                end
                if (hs_armed) begin
                    first_hs_cyc = cyc;
                    hs_armed = 1'b0;
                end
                acc_n++;
                last_hs_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [3:0] b, input logic [4:0] n);
        logic [3:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 4'(i);
            exp_q.push_back('{d: 8'({4'd0, a}) + 8'd32, l: (i == int'(n) - 1)});
        end
        start     = 1'b1;
        base_addr = b;
        len       = n;
        armed     = (n != 0);
        hs_armed  = (n != 0);
        tick();
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        int d0 = done_n;
        while (done_n == d0 && n < maxc) begin
            tick();
            n++;
        end
        if (done_n == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, required one", maxc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        m_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, rom_r_en, m_valid, m_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/ren/valid/last=%b, required 00000",
                     {busy, done, rom_r_en, m_valid, m_last});
        end
        checks++;
        if (rom_addr !== 4'd0 || m_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h data=%h, required 0 0", rom_addr, m_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_stream();
        int d0 = done_n;
        m_ready = 1'b1;
        start_xfer(4'd0, 5'd16);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: got %b, required 1", busy);
        end
        wait_done(60);
        checks++;
        if (first_v_cyc - start_cyc != 2) begin
            errors++;
            $display("FAIL full_latency: got %0d, required 2", first_v_cyc - start_cyc);
        end
        checks++;
        if (last_hs_cyc - first_hs_cyc != 15) begin
            errors++;
            $display("FAIL full_throughput: span %0d, required 15", last_hs_cyc - first_hs_cyc);
        end
        checks++;
        if (done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL full_done_time: got %0d, required %0d", done_cyc, last_hs_cyc + 1);
        end
        checks++;
        if (exp_q.size() != 0 || done_n - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end: left=%0d dones=%0d busy=%b, required 0 1 0",
                     exp_q.size(), done_n - d0, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] ea [4];
        ea[0] = 4'd14;
        ea[1] = 4'd15;
        ea[2] = 4'd0;
        ea[3] = 4'd1;
        addr_log.delete();
        m_ready = 1'b1;
        start_xfer(4'd14, 5'd4);
        wait_done(30);
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("FAIL wrap_reads: got %0d, required 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[i] !== ea[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %0d, required %0d", i, addr_log[i], ea[i]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_left: got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_n;
        int a0 = acc_n;
        int k = 0;
        max_pend = 0;
        m_ready = 1'b1;
        start_xfer(4'd3, 5'd8);
        while (done_n == d0 && k < 100) begin
            if (k >= 6 && k < 11) m_ready = 1'b0;
            else m_ready = k[0];
            tick();
            k++;
        end
        m_ready = 1'b1;
        checks++;
        if (done_n == d0) begin
            errors++;
            $display("FAIL bp_timeout: no done, required one");
        end
        checks++;
        if (acc_n - a0 != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: words=%0d left=%0d, required 8 0", acc_n - a0, exp_q.size());
        end
        checks++;
        if (max_pend > 2) begin
            errors++;
            $display("FAIL bp_occupancy: got %0d, required <=2", max_pend);
        end
    endtask

    task automatic test_zero_len();
        int i0 = issued_n;
        int v0 = valid_n;
        int d0 = done_n;
        start_xfer(4'd7, 5'd0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b, required 1", done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width: got %b, required 0", done);
        end
        repeat (4) tick();
        checks++;
        if (issued_n != i0 || valid_n != v0 || done_n - d0 != 1) begin
            errors++;
            $display("FAIL zero_quiet: reads=%0d valids=%0d dones=%0d, required 0 0 1",
                     issued_n - i0, valid_n - v0, done_n - d0);
        end
    endtask

    task automatic test_start_busy();
        int d0 = done_n;
        int a0 = acc_n;
        m_ready = 1'b1;
        start_xfer(4'd0, 5'd6);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_busy: got %b, required 1", busy);
        end
        start = 1'b1;
        base_addr = 4'd8;
        len = 5'd2;
        tick();
        start = 1'b0;
        wait_done(40);
        repeat (6) tick();
        checks++;
        if (done_n - d0 != 1 || acc_n - a0 != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_result: dones=%0d words=%0d left=%0d, required 1 6 0",
                     done_n - d0, acc_n - a0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int a0 = acc_n;
        int d0;
        int k = 0;
        m_ready = 1'b1;
        start_xfer(4'd0, 5'd10);
        while (acc_n - a0 < 3 && k < 20) begin
            tick();
            k++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, rom_r_en, m_valid, m_last} !== 5'b0
            || m_data !== 8'd0 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid: ctrl=%b data=%h addr=%h, required 00000 0 0",
                     {busy, done, rom_r_en, m_valid, m_last}, m_data, rom_addr);
        end
        rst = 1'b0;
        exp_q.delete();
        d0 = done_n;
        repeat (5) tick();
        checks++;
        if (done_n != d0 || valid_n < 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d dones, required 0", done_n - d0);
        end
        a0 = acc_n;
        start_xfer(4'd5, 5'd2);
        wait_done(30);
        checks++;
        if (acc_n - a0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_restart: words=%0d left=%0d, required 2 0",
                     acc_n - a0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
